prio_encoder_rr: RTL

Parametrised, registered successor to the 8-line priority encoder. It accepts an N-bit request vector through an EN/RDY handshake. It returns the winning index, a one-hot grant and a no-request flag one cycle later, in either fixed-priority or round-robin mode. It sits between request producers and the transmission link, which consumes the compact index.

---
 rtl/enc_pkg.sv | 12 +
 rtl/prio_find.sv | 45 ++++
 rtl/prio_encoder_rr.sv | 92 +++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered round-robin priority encoder.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for N request lines; at least one bit even for N=2.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-bit search starting at start_i and descending with wrap.
module prio_find
    import enc_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    vec_i,
    input  logic [IDXW-1:0] start_i,
    output logic [IDXW-1:0] idx_o,
    output logic [N-1:0]    onehot_o,
    output logic            none_o
);

    logic [IDXW-1:0] base;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] hi;
    logic            found;
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;

    always_comb begin
        // Rotate so vec_i[start_i] sits at the MSB; the search order then
        // becomes a plain top-down scan of rot.
        base  = (start_i == IDXW'(N - 1)) ? '0 : start_i + 1'b1;
        rot   = N'({vec_i, vec_i} >> base);
        hi    = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                hi    = IDXW'(j);
                found = 1'b1;
            end
        end
        sum = {1'b0, base} + {1'b0, hi};
        if (sum >= (IDXW + 1)'(N)) begin
            sum = sum - (IDXW + 1)'(N);
        end
        idx      = found ? sum[IDXW-1:0] : '0;
        idx_o    = idx;
        onehot_o = found ? (N'(1) << idx) : '0;
        none_o   = !found;
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed/round-robin modes and EN/RDY handshakes.
module prio_encoder_rr
    import enc_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = idx_width(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    enc_req,
    input  logic            enc_mode_rr,
    input  logic            EN_enc,
    output logic            RDY_enc,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    out_onehot,
    output logic            out_none,
    output logic            RDY_out,
    input  logic            EN_out
);

    // Handshake: a transfer happens on a rising edge where EN and RDY are both
    // high; EN while RDY is low is ignored and the sender must hold its data.
    localparam logic [IDXW-1:0] PTR_RST = IDXW'(N - 1);

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    onehot_q, onehot_d;
    logic            none_q, none_d;
    logic            rdy_q, rdy_d;

    logic            accept;
    logic            pop;
    logic [IDXW-1:0] start;
    logic [IDXW-1:0] find_idx;
    logic [N-1:0]    find_onehot;
    logic            find_none;

    assign RDY_enc = !rdy_q | EN_out;
    assign accept  = EN_enc & RDY_enc;
    assign pop     = EN_out & rdy_q;
    assign start   = (enc_mode_rr == MODE_RR) ? ptr_q : PTR_RST;

    prio_find #(.N(N)) u_find (
        .vec_i    (enc_req),
        .start_i  (start),
        .idx_o    (find_idx),
        .onehot_o (find_onehot),
        .none_o   (find_none)
    );

    always_comb begin
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        none_d   = none_q;
        rdy_d    = rdy_q;
        if (accept) begin
            idx_d    = find_idx;
            onehot_d = find_onehot;
            none_d   = find_none;
            rdy_d    = 1'b1;
            // Next search starts just below the winner so it goes last.
            if ((enc_mode_rr == MODE_RR) && !find_none) begin
                ptr_d = (find_idx == '0) ? PTR_RST : find_idx - 1'b1;
            end
        end else if (pop) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q    <= PTR_RST;
            idx_q    <= '0;
            onehot_q <= '0;
            none_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            none_q   <= none_d;
            rdy_q    <= rdy_d;
        end
    end

    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_none   = none_q;
    assign RDY_out    = rdy_q;

endmodule
